// File: rtl/axistream_snooper.sv
// AXI Stream ingress tap: copies each 64-bit packet into the offered packetmem buffer, reports its length, counts drops.
// Optional macro AXIS_SNOOPER_TKEEP_EN: last-beat byte count taken from TKEEP instead of a fixed 8.
module axistream_snooper #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           TDATA,
    input  logic                  TVALID,
    input  logic                  TLAST,
    input  logic [7:0]            TKEEP,
    output logic                  TREADY,
    output logic [ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [63:0]           snooper_wr_data,
    output logic                  snooper_wr_en,
    output logic                  snooper_done,
    input  logic                  ready_for_snooper,
    output logic [31:0]           len_from_snooper,
    output logic [31:0]           drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DROP    = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [63:0]           wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           drop_q, drop_d;

    logic                  accept;
    logic [3:0]            last_bytes;
    logic [31:0]           drop_inc;
    logic [31:0]           capture_len;

    // The tap never stalls the link; it is only deaf while held in reset.
    assign TREADY   = rst_n;
    assign accept   = TVALID && TREADY;
    assign drop_inc = (drop_q == 32'hFFFF_FFFF) ? drop_q : drop_q + 32'd1;

`ifdef AXIS_SNOOPER_TKEEP_EN
    always_comb begin
        last_bytes = 4'($countones(TKEEP));
        if (last_bytes == 4'd0) begin
            last_bytes = 4'd8;
        end
    end
`else
    logic unused_tkeep;
    assign unused_tkeep = ^TKEEP;
    assign last_bytes   = 4'd8;
`endif

    // wr_addr_q still holds the previous beat's index, so the finishing beat is index wr_addr_q + 1.
    assign capture_len = ((32'(wr_addr_q) + 32'd1) << 3) + 32'(last_bytes);

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        len_d     = len_q;
        drop_d    = drop_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (ready_for_snooper && !done_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = TDATA;
                        if (TLAST) begin
                            done_d = 1'b1;
                            len_d  = 32'(last_bytes);
                        end else begin
                            state_d = CAPTURE;
                        end
                    end else begin
                        drop_d = drop_inc;
                        if (!TLAST) begin
                            state_d = DROP;
                        end
                    end
                end
                CAPTURE: begin
                    if (wr_addr_q == '1) begin
                        drop_d  = drop_inc;
                        state_d = TLAST ? IDLE : DROP;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                        wr_data_d = TDATA;
                        if (TLAST) begin
                            done_d  = 1'b1;
                            len_d   = capture_len;
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (TLAST) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            len_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            len_q     <= len_d;
            drop_q    <= drop_d;
        end
    end

    assign snooper_wr_en    = wr_en_q;
    assign snooper_wr_addr  = wr_addr_q;
    assign snooper_wr_data  = wr_data_q;
    assign snooper_done     = done_q;
    assign len_from_snooper = len_q;
    assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_axistream_snooper.sv
// Bench for axistream_snooper: packet-level reference model, per-cycle compare, directed and random traffic.
module tb_axistream_snooper;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   tdata = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic [7:0]    tkeep = '0;
    logic          ready = 1'b0;

    logic          TREADY;
    logic [AW-1:0] snooper_wr_addr;
    logic [63:0]   snooper_wr_data;
    logic          snooper_wr_en;
    logic          snooper_done;
    logic [31:0]   len_from_snooper;
    logic [31:0]   drop_cnt;

    always #5 clk = ~clk;

    axistream_snooper #(.ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .TDATA             (tdata),
        .TVALID            (tvalid),
        .TLAST             (tlast),
        .TKEEP             (tkeep),
        .TREADY            (TREADY),
        .snooper_wr_addr   (snooper_wr_addr),
        .snooper_wr_data   (snooper_wr_data),
        .snooper_wr_en     (snooper_wr_en),
        .snooper_done      (snooper_done),
        .ready_for_snooper (ready),
        .len_from_snooper  (len_from_snooper),
        .drop_cnt          (drop_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int last_bytes(input logic [7:0] k);
`ifdef AXIS_SNOOPER_TKEEP_EN
        int n;
        n = $countones(k);
        return (n == 0) ? 8 : n;
`else
        return (k == k) ? 8 : 8;
`endif
    endfunction

    // Reference model: tracks each packet by beat index and decides capture once at packet start.
    logic [63:0]   exp_q[$];
    logic          exp_wr_en = 1'b0;
    logic          exp_done = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   exp_len = '0;
    logic [31:0]   exp_drop = '0;
    bit            in_pkt = 1'b0;
    bit            capturing = 1'b0;
    int            beat_idx = 0;
    bit            started = 1'b0;

    always @(posedge clk) begin
        logic n_wr_en;
        logic n_done;
        started = 1'b1;
        if (!rst_n) begin
            exp_wr_en = 1'b0;
            exp_done  = 1'b0;
            exp_addr  = '0;
            exp_len   = '0;
            exp_drop  = '0;
            in_pkt    = 1'b0;
            capturing = 1'b0;
            exp_q.delete();
        end else begin
            n_wr_en = 1'b0;
            n_done  = 1'b0;
            if (tvalid) begin
                if (!in_pkt) begin
                    in_pkt    = 1'b1;
                    beat_idx  = 0;
                    capturing = ready && !exp_done;
                    if (!capturing && exp_drop != 32'hFFFF_FFFF) exp_drop = exp_drop + 1;
                end else begin
                    beat_idx++;
                end
                if (capturing) begin
                    if (beat_idx < DEPTH) begin
                        n_wr_en  = 1'b1;
                        exp_addr = beat_idx[AW-1:0];
                        exp_q.push_back(tdata);
                        if (tlast) begin
                            n_done  = 1'b1;
                            exp_len = 32'(8 * beat_idx + last_bytes(tkeep));
                        end
                    end else begin
                        capturing = 1'b0;
                        if (exp_drop != 32'hFFFF_FFFF) exp_drop = exp_drop + 1;
                    end
                end
                if (tlast) in_pkt = 1'b0;
            end
            exp_wr_en = n_wr_en;
            exp_done  = n_done;
        end
    end

    int wr_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("tready", 64'(TREADY), 64'(rst_n));
            chk("wr_en", 64'(snooper_wr_en), 64'(exp_wr_en));
            chk("done", 64'(snooper_done), 64'(exp_done));
            chk("len", 64'(len_from_snooper), 64'(exp_len));
            chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            if (exp_wr_en && exp_q.size() > 0) begin
                chk("wr_addr", 64'(snooper_wr_addr), 64'(exp_addr));
                chk("wr_data", snooper_wr_data, exp_q.pop_front());
            end
            if (snooper_wr_en === 1'b1) wr_cnt++;
            if (snooper_done === 1'b1) done_cnt++;
        end
    end

    task automatic drive(input logic v, input logic l, input logic [63:0] d, input logic [7:0] k,
                         input logic rdy);
        tvalid = v;
        tlast  = l;
        tdata  = d;
        tkeep  = k;
        ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, {$urandom, $urandom}, 8'h00, rdy);
    endtask

    task automatic send(input int n, input logic rdy, input logic [7:0] last_keep);
        for (int i = 0; i < n; i++)
            drive(1'b1, i == n - 1, {$urandom, $urandom}, (i == n - 1) ? last_keep : 8'($urandom), rdy);
    endtask

    int w0;
    int d0;

    initial begin
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_wr_en_lit", 64'(snooper_wr_en), 64'd0);
        chk("rst_done_lit", 64'(snooper_done), 64'd0);
        chk("rst_len_lit", 64'(len_from_snooper), 64'd0);
        chk("rst_drop_lit", 64'(drop_cnt), 64'd0);
        chk("rst_tready_lit", 64'(TREADY), 64'd0);
        rst_n = 1'b1;
        idle(1, 1'b1);

        // 3-beat packet, continuous valid
        w0 = wr_cnt; d0 = done_cnt;
        drive(1'b1, 1'b0, 64'hD0, 8'hFF, 1'b1);
        drive(1'b1, 1'b0, 64'hD1, 8'hFF, 1'b1);
        drive(1'b1, 1'b1, 64'hD2, 8'hFF, 1'b1);
        idle(2, 1'b1);
        chk("t1_writes", 64'(wr_cnt - w0), 64'd3);
        chk("t1_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_len", 64'(len_from_snooper), 64'd24);

        // not ready at packet start; ready rising mid-packet is ignored
        w0 = wr_cnt; d0 = done_cnt;
        drive(1'b1, 1'b0, 64'hA0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 64'hA1, 8'hFF, 1'b1);
        chk("t2_drop_mid", 64'(drop_cnt), 64'd1);
        idle(1, 1'b1);
        chk("t2_no_write", 64'(wr_cnt - w0), 64'd0);
        send(1, 1'b1, 8'hFF);
        idle(2, 1'b1);
        chk("t2_writes", 64'(wr_cnt - w0), 64'd1);
        chk("t2_done", 64'(done_cnt - d0), 64'd1);
        chk("t2_drop", 64'(drop_cnt), 64'd1);
        chk("t2_len", 64'(len_from_snooper), 64'd8);

        // overflow: 5 beats into a 4-word buffer
        w0 = wr_cnt; d0 = done_cnt;
        send(5, 1'b1, 8'hFF);
        idle(1, 1'b1);
        chk("t3_ovf_writes", 64'(wr_cnt - w0), 64'd4);
        chk("t3_ovf_done", 64'(done_cnt - d0), 64'd0);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        send(1, 1'b1, 8'hFF);
        idle(2, 1'b1);
        chk("t3_done", 64'(done_cnt - d0), 64'd1);
        chk("t3_len", 64'(len_from_snooper), 64'd8);

        // valid gaps 1,0,0,1,1
        w0 = wr_cnt; d0 = done_cnt;
        drive(1'b1, 1'b0, 64'hB0, 8'hFF, 1'b1);
        idle(2, 1'b1);
        drive(1'b1, 1'b0, 64'hB1, 8'hFF, 1'b1);
        drive(1'b1, 1'b1, 64'hB2, 8'hFF, 1'b1);
        idle(2, 1'b1);
        chk("t4_writes", 64'(wr_cnt - w0), 64'd3);
        chk("t4_done", 64'(done_cnt - d0), 64'd1);
        chk("t4_len", 64'(len_from_snooper), 64'd24);

        // partial last beat
        send(2, 1'b1, 8'h07);
        idle(2, 1'b1);
`ifdef AXIS_SNOOPER_TKEEP_EN
        chk("t5_len", 64'(len_from_snooper), 64'd11);
`else
        chk("t5_len", 64'(len_from_snooper), 64'd16);
`endif

        // reset during beat 2 of 4
        d0 = done_cnt;
        drive(1'b1, 1'b0, 64'hC0, 8'hFF, 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 64'hC1, 8'hFF, 1'b1);
        rst_n = 1'b1;
        chk("t6_wr_en_lit", 64'(snooper_wr_en), 64'd0);
        chk("t6_done_lit", 64'(snooper_done), 64'd0);
        chk("t6_len_lit", 64'(len_from_snooper), 64'd0);
        chk("t6_drop_lit", 64'(drop_cnt), 64'd0);
        chk("t6_addr_lit", 64'(snooper_wr_addr), 64'd0);
        drive(1'b1, 1'b0, 64'hC2, 8'hFF, 1'b1);
        drive(1'b1, 1'b1, 64'hC3, 8'hFF, 1'b1);
        idle(2, 1'b1);
        chk("t6_done", 64'(done_cnt - d0), 64'd1);
        chk("t6_len", 64'(len_from_snooper), 64'd16);

        // random traffic: lengths across the overflow boundary, gaps, back-to-back, sporadic reset
        for (int p = 0; p < 400; p++) begin
            int n;
            int kn;
            logic [7:0] lk;
            n  = $urandom_range(1, 7);
            kn = $urandom_range(0, 8);
            lk = (kn == 8) ? 8'hFF : 8'((1 << kn) - 1);
            for (int b = 0; b < n; b++) begin
                while ($urandom_range(0, 3) == 0) idle(1, $urandom_range(0, 9) < 7);
                rst_n = ($urandom_range(0, 299) != 0);
                drive(1'b1, b == n - 1, {$urandom, $urandom}, (b == n - 1) ? lk : 8'($urandom),
                      $urandom_range(0, 9) < 7);
                rst_n = 1'b1;
            end
            idle($urandom_range(0, 2), $urandom_range(0, 9) < 7);
        end
        idle(3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axistream_snooper.md
Name: axistream_snooper

Overview:
- Ingress stage directly upstream of packetmem; the mirror of the AXI Stream forwarder on the egress side.
- Taps an incoming 64-bit AXI Stream and writes each packet into the packetmem buffer currently offered to it.
- Reports the packet's byte length and issues a 1-cycle done pulse.
- Packets that cannot be captured are dropped whole and counted. The tap never back-pressures the link.

Parameters:
- ADDR_WIDTH, 10, packetmem word address width; buffer capacity is 2**ADDR_WIDTH 64-bit words.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- TDATA  input  64  stream data.
- TVALID  input  1  beat valid.
- TLAST  input  1  last beat of packet.
- TKEEP  input  8  byte enables, last beat only (used only with AXIS_SNOOPER_TKEEP_EN).
- TREADY  output  1  constant 1 out of reset; 0 while rst_n low.
- snooper_wr_addr  output  ADDR_WIDTH  packetmem write address.
- snooper_wr_data  output  64  packetmem write data.
- snooper_wr_en  output  1  write strobe.
- snooper_done  output  1  1-cycle pulse: packet fully written.
- ready_for_snooper  input  1  packetmem has a free buffer for us.
- len_from_snooper  output  32  byte length of last completed packet.
- drop_cnt  output  32  saturating count of dropped packets.

Behaviour:
- Reset (rst_n=0 at posedge) clears every register:
  - outputs wr_en, done, wr_addr, wr_data, len_from_snooper and drop_cnt all go to 0;
  - TREADY goes to 0;
  - state goes to IDLE.
- A beat is "accepted" when TVALID && TREADY.
- State machine:
  - IDLE: at a packet boundary. On an accepted beat:
    - if ready_for_snooper && !snooper_done, capture the beat at address 0 and go to CAPTURE;
    - otherwise go to DROP.
    - If that beat also has TLAST: a captured packet completes immediately (single-beat packet, see TLAST below); a dropped packet increments drop_cnt and stays IDLE.
  - CAPTURE: each accepted beat is written at the previous address + 1.
    - On TLAST: write the beat, pulse done, return to IDLE.
    - If a beat would need address 2**ADDR_WIDTH (overflow): do not write it, no done, increment drop_cnt, go to DROP. That beat's TLAST still counts: if set, go to IDLE instead.
  - DROP: discard beats until the accepted beat carrying TLAST, then go to IDLE. drop_cnt increments once per dropped packet, on entry.
- Write latency:
  - wr_en, wr_addr and wr_data are registered, asserted exactly 1 cycle after the accepted beat.
  - wr_en is high for exactly one cycle per written beat.
- Completion (TLAST beat captured):
  - snooper_done pulses in the same cycle as the final wr_en;
  - len_from_snooper updates in that same cycle and holds until the next completion.
- Length arithmetic: len = 8*(beats-1) + bytes(last beat), computed in 32 bits. Without the optional feature, bytes(last beat) = 8.
- ready_for_snooper:
  - sampled only at packet start;
  - deassertion mid-CAPTURE is ignored, because the buffer is owned until done;
  - masked while snooper_done=1, so packetmem gets one cycle to update. A first beat arriving in the done cycle is dropped.
  - Senders need one idle cycle between packets for guaranteed capture.
- TVALID low mid-packet: no write, state and address held.
- drop_cnt saturates at 0xFFFFFFFF.
- Reset mid-packet: return to IDLE. The remaining beats of that packet are treated as a new packet (no resync); done is never emitted for the partial packet.

Optional Feature:
- Macro: AXIS_SNOOPER_TKEEP_EN.
- Defined: the last beat's byte count is popcount(TKEEP) for contiguous-low TKEEP. TKEEP=0 on a last beat counts as 8.
- Undefined: TKEEP is ignored, every beat counts 8 bytes, and len is always a multiple of 8.

Test Plan:
- ready=1, 3-beat packet D0..D2 (TLAST on D2), TVALID continuous -> wr_en 3 cycles at addr 0,1,2 one cycle after each beat; done with third write; len=24.
- ready=0 at first beat of 2-beat packet, ready=1 from second beat -> no wr_en, no done, drop_cnt=1; next packet after 1 idle cycle is captured.
- ADDR_WIDTH=2, 5-beat packet -> writes at addr 0..3, no done, drop_cnt=1; following 1-beat packet -> write addr 0, done, len=8.
- TVALID gaps (1,0,0,1,1 with TLAST on the last) -> exactly 3 writes at addr 0,1,2, done once.
- With AXIS_SNOOPER_TKEEP_EN: 2-beat packet, last TKEEP=8'h07 -> len=11. Without the macro, same stimulus -> len=16.
- rst_n low for 1 cycle during CAPTURE beat 2 of 4 -> all outputs 0 next cycle; beats 3-4 form a 2-beat packet (captured if ready); no done for the interrupted packet.
